// File: rtl/onecold_enc_sync_if.sv
// Event channel from the one-cold encoder to downstream control logic.
interface onecold_enc_sync_if;
   logic [2:0] code;
   logic       multi;
   logic       valid;
   logic       ready;

   modport master (output code, output multi, output valid, input ready);
   modport slave  (input code, input multi, input valid, output ready);
endinterface

// File: rtl/onecold_enc_sync.sv
// Synchronises, debounces and encodes eight async one-cold select lines
// into single-shot index events on a valid/ready channel.
//
//  state  | meaning
//  TRACK  | candidate pattern seen, counting equal synchronised samples
//  STABLE | candidate committed, waiting for the pattern to change
//  EMPTY  | no event pending on the output channel
//  HOLD   | event presented, waiting for ready
module onecold_enc_sync #(
   parameter int    SYNC_STAGES     = 2,
   parameter int    DEBOUNCE_CYCLES = 4,
   parameter string MULTI_MODE      = "Priority"
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [7:0]                x_n_i,
   input  logic                      clr_ovr_i,
   output logic                      err_o,
   output logic                      overrun_o,
   onecold_enc_sync_if.master        evt
);

   localparam bit DROP   = (MULTI_MODE == "Drop");
   localparam bit DC_ONE = (DEBOUNCE_CYCLES <= 1);
   localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 2 : 0);

   typedef enum logic {TRACK, STABLE} deb_state_t;
   typedef enum logic {EMPTY, HOLD}   out_state_t;

   logic [7:0]       sync_q [SYNC_STAGES];
   logic [7:0]       s;
   logic [7:0]       cand_q, cand_d;
   logic [7:0]       committed_q, committed_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   deb_state_t       deb_q, deb_d;
   out_state_t       out_q, out_d;
   logic [2:0]       code_q, code_d;
   logic             multi_q, multi_d;
   logic             ovr_q, ovr_d;
   logic             err_q, err_d;

   logic             commit;
   logic             new_pat;
   logic [7:0]       low;
   logic             multi_w;
   logic [2:0]       code_w;
   logic             ev;

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 8'hFF;
      end else begin
         sync_q[0] <= x_n_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // Debounce: the capture sample counts as the first of DEBOUNCE_CYCLES,
   // so commit happens on the edge where the last required sample arrives.
   always_comb begin
      deb_d  = deb_q;
      cand_d = cand_q;
      cnt_d  = cnt_q;
      commit = 1'b0;
      if (s != cand_q) begin
         cand_d = s;
         cnt_d  = '0;
         if (DC_ONE) begin
            deb_d  = STABLE;
            commit = 1'b1;
         end else begin
            deb_d = TRACK;
         end
      end else if (deb_q == TRACK) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CNT_LAST) begin
            deb_d  = STABLE;
            commit = 1'b1;
         end
      end
   end

   always_comb begin
      committed_d = commit ? cand_d : committed_q;
      new_pat     = commit && (cand_d != committed_q) && (cand_d != 8'hFF);
      low         = ~cand_d;
      multi_w     = |(low & (low - 8'd1));
      code_w      = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (low[i]) code_w = 3'(i);
      end
      ev    = new_pat && (!multi_w || !DROP);
      err_d = new_pat && multi_w && DROP;
   end

   always_comb begin
      out_d   = out_q;
      code_d  = code_q;
      multi_d = multi_q;
      ovr_d   = ovr_q;
      if (clr_ovr_i) ovr_d = 1'b0;
      case (out_q)
         EMPTY: begin
            if (ev) begin
               code_d  = code_w;
               multi_d = multi_w;
               out_d   = HOLD;
            end
         end
         HOLD: begin
            if (evt.ready) begin
               if (ev) begin
                  code_d  = code_w;
                  multi_d = multi_w;
               end else begin
                  out_d = EMPTY;
               end
            end else if (ev) begin
               ovr_d = 1'b1;
            end
         end
         default: out_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_q      <= 8'hFF;
         committed_q <= 8'hFF;
         cnt_q       <= '0;
         deb_q       <= STABLE;
         out_q       <= EMPTY;
         code_q      <= 3'd0;
         multi_q     <= 1'b0;
         ovr_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         cand_q      <= cand_d;
         committed_q <= committed_d;
         cnt_q       <= cnt_d;
         deb_q       <= deb_d;
         out_q       <= out_d;
         code_q      <= code_d;
         multi_q     <= multi_d;
         ovr_q       <= ovr_d;
         err_q       <= err_d;
      end
   end

   assign evt.code  = code_q;
   assign evt.multi = multi_q;
   assign evt.valid = (out_q == HOLD);
   assign err_o     = err_q;
   assign overrun_o = ovr_q;

endmodule
